serial_addsub: RTL and testbench



---
 rtl/serial_addsub_pkg.sv | 36 +++
 rtl/addsub_bit_cell.sv | 34 +++
 rtl/serial_addsub.sv | 131 +++++++++++++
 tb/tb_serial_addsub.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// ============================================================================
// Module  : serial_addsub_pkg
// Purpose : Shared types and constants for the bit-serial adder/subtractor.
//           Contents:
//             state_t - controller states (IDLE, RUN, DONE)
//             OP_ADD  - op encoding for A+B
//             OP_SUB  - op encoding for A-B
//             clog2() - bit-counter width for a given operand width
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Width needed to count 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/addsub_bit_cell.sv
// ============================================================================
// Module  : addsub_bit_cell
// Purpose : Single-bit full adder with conditional inversion of B, the one
//           arithmetic cell shared by every bit position of serial_addsub.
// Ports   : a_bit - operand A bit
//           b_bit - operand B bit (inverted when op=1)
//           op    - 0 = add, 1 = subtract
//           cin   - carry in
//           s     - sum bit
//           cout  - carry out
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic op,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic bit_b;
  logic half;

  assign bit_b = b_bit ^ op;
  assign half  = a_bit ^ bit_b;
  assign s     = half ^ cin;
  assign cout  = (a_bit & bit_b) | (cin & half);

endmodule

`default_nettype wire

// File: rtl/serial_addsub.sv
// ============================================================================
// Module  : serial_addsub
// Purpose : Bit-serial adder/subtractor producing one result bit per clock,
//           LSB first, through a single shared addsub_bit_cell. Handshake is
//           start/busy/done; result is held until the next operation ends.
// Params  : WIDTH - operand/result width (2..32)
// Ports   : clk, rst_n (async active-low)
//           start  - request, honoured only when busy=0
//           op     - 0 = A+B, 1 = A-B
//           a, b   - operands, latched on an accepted start
//           busy   - operation in progress
//           done   - one-cycle pulse when result/carry update
//           result - sum/difference modulo 2^WIDTH
//           carry  - add: carry-out, subtract: borrow (A<B unsigned)
//           overflow - signed overflow (only with SERIAL_ADDSUB_OVF_EN)
// Config  : define SERIAL_ADDSUB_OVF_EN to add the overflow output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef SERIAL_ADDSUB_OVF_EN
  output logic             overflow,
`endif
  output logic             carry
);

  localparam int CNT_W = clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] sr;        // result bits collected so far, MSB-aligned
  logic [WIDTH-1:0] sr_full;   // collection after this edge's bit shifts in
  logic             c;
  logic             op_q;
  logic [CNT_W-1:0] cnt;
  logic             s;
  logic             c_next;
  logic             accept;
  logic             last_bit;

  addsub_bit_cell u_cell (
    .a_bit (sa[0]),
    .b_bit (sb[0]),
    .op    (op_q),
    .cin   (c),
    .s     (s),
    .cout  (c_next)
  );

  assign accept   = start && (state != RUN);
  assign last_bit = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign sr_full  = {s, sr};
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Working registers. Outputs are only written on the final RUN edge so the
  // previous result stays visible for the whole of the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      c        <= 1'b0;
      op_q     <= OP_ADD;
      cnt      <= '0;
      result   <= '0;
      carry    <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      overflow <= 1'b0;
`endif
    end else if (accept) begin
      sa   <= a;
      sb   <= b;
      op_q <= op;
      c    <= (op == OP_SUB);  // the +1 of A + ~B + 1
      cnt  <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      c   <= c_next;
      sr  <= sr_full[WIDTH-1:1];
      cnt <= cnt + CNT_W'(1);
      if (last_bit) begin
        result <= sr_full;
        // A set carry-out on subtract means no borrow occurred.
        carry  <= (op_q == OP_SUB) ? ~c_next : c_next;
`ifdef SERIAL_ADDSUB_OVF_EN
        // On the MSB edge, c is the carry into the MSB.
        overflow <= c ^ c_next;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
// ============================================================================
// Module  : tb_serial_addsub
// Purpose : Scoreboard testbench for serial_addsub (WIDTH=4). Stimulus pushes
//           hand-computed expectations; a negedge monitor pops and compares
//           on every done pulse and checks output hold while busy.
// Config  : define SERIAL_ADDSUB_OVF_EN to also check overflow.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_addsub;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             op = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             overflow;
`endif

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
`ifdef SERIAL_ADDSUB_OVF_EN
    .overflow (overflow),
`endif
    .carry    (carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             cy;
    logic             ovf;
    int               cyc;
  } exp_t;

  exp_t             sbq[$];
  int               cyc = 0;
  int               n_total = 0;
  int               n_pass = 0;
  logic [WIDTH-1:0] last_res = '0;
  logic             last_cy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic iop, input logic [WIDTH-1:0] er,
                       input logic ec, input logic eo);
    exp_t e;
    e.res = er;
    e.cy  = ec;
    e.ovf = eo;
    e.cyc = cyc + 1 + WIDTH;
    sbq.push_back(e);
    a     = ia;
    b     = ib;
    op    = iop;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is seen.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_total++;
      $display("FAIL wait_done: got no done expected done within 20 cycles");
    end
  endtask

  // Monitor
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (done) begin
        if (sbq.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          check("result", result, e.res);
          check("carry", carry, e.cy);
          check("latency_cycle", cyc, e.cyc);
`ifdef SERIAL_ADDSUB_OVF_EN
          check("overflow", overflow, e.ovf);
`endif
          last_res = e.res;
          last_cy  = e.cy;
        end
      end else if (busy) begin
        check("hold_result", result, last_res);
        check("hold_carry", carry, last_cy);
      end
    end
  end

  initial begin
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_carry", carry, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Subtract, no borrow: 9-3 (signed -7-3 overflows)
    issue(4'd9, 4'd3, 1'b1, 4'd6, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);
    // Subtract with borrow: 3-9
    issue(4'd3, 4'd9, 1'b1, 4'hA, 1'b1, 1'b1);
    wait_done();
    @(negedge clk);
    // Signed overflow: 7-(-1)
    issue(4'd7, 4'hF, 1'b1, 4'd8, 1'b1, 1'b1);
    wait_done();
    @(negedge clk);
    // Add wrap-around
    issue(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
    wait_done();
    @(negedge clk);
    issue(4'd5, 4'd2, 1'b0, 4'd7, 1'b0, 1'b0);
    wait_done();
    @(negedge clk);

    // Busy protection: a start during RUN must be ignored.
    issue(4'd9, 4'd3, 1'b1, 4'd6, 1'b0, 1'b1);
    a     = 4'd1;
    b     = 4'd1;
    op    = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    // Back-to-back starts during DONE
    issue(4'd2, 4'd5, 1'b0, 4'd7, 1'b0, 1'b0);
    wait_done();
    issue(4'hC, 4'h6, 1'b0, 4'h2, 1'b1, 1'b0);
    wait_done();
    @(negedge clk);

    // Reset mid-operation
    issue(4'd9, 4'd3, 1'b1, 4'd6, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sbq.delete();
    last_res = '0;
    last_cy  = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_carry", carry, 0);
    @(negedge clk);
    @(negedge clk);
    check("midrst_busy_held", busy, 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(4'd4, 4'd4, 1'b1, 4'd0, 1'b0, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);

    check("queue_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
